booth_mul_arbiter: RTL and testbench

BOOTH_MUL_ARBITER -- requirements
Module: booth_mul_arbiter

---
 rtl/booth_mul_arbiter.sv | 115 +++++++++++
 tb/tb_booth_mul_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin front end that shares one external pipelined
// signed multiplier among NREQ requesters. Grants are combinational, operands
// are registered toward the multiplier, and a tag pipeline routes each product
// back to its requester MUL_LAT+2 cycles after acceptance.
// Optional build macro: MULARB_PERF_EN adds a 32-bit accepted-operation counter.
module booth_mul_arbiter #(
  parameter int N       = 16,
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*N-1:0]   req_a,
  input  logic [NREQ*N-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic [N-1:0]        mul_a,
  output logic [N-1:0]        mul_b,
  input  logic [2*N-1:0]      mul_prod,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [2*N-1:0]      rsp_prod,
  output logic                busy,
  output logic [31:0]         perf_cnt
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]  ptr;
  logic [IW-1:0]  grant_idx;
  logic [IW-1:0]  cand;
  logic           grant;
  logic [N-1:0]   a_slice [NREQ];
  logic [N-1:0]   b_slice [NREQ];
  logic [MUL_LAT:0] tag_valid;
  logic [IW-1:0]  tag_idx [MUL_LAT+1];

  // Unpack the flat operand buses into per-requester slices.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign a_slice[gi] = req_a[gi*N +: N];
    assign b_slice[gi] = req_b[gi*N +: N];
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    req_ready = '0;
    if (en && rst) begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = IW'((int'(ptr) + k) % NREQ);
        if (!grant && req_valid[cand]) begin
          grant     = 1'b1;
          grant_idx = cand;
        end
      end
    end
    req_ready[grant_idx] = grant;
  end

  // Pointer update and operand registers; operands hold when nothing is granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr   <= IW'(NREQ - 1);
      mul_a <= '0;
      mul_b <= '0;
    end else if (grant) begin
      ptr   <= grant_idx;
      mul_a <= a_slice[grant_idx];
      mul_b <= b_slice[grant_idx];
    end
  end

  // Free-running tag pipeline that tracks which requester owns each product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_valid <= '0;
      for (int s = 0; s <= MUL_LAT; s++) tag_idx[s] <= '0;
    end else begin
      tag_valid  <= {tag_valid[MUL_LAT-1:0], grant};
      tag_idx[0] <= grant_idx;
      for (int s = 1; s <= MUL_LAT; s++) tag_idx[s] <= tag_idx[s-1];
    end
  end

  // Capture the product when its tag reaches the last stage and strobe the owner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= '0;
      rsp_prod  <= '0;
    end else begin
      rsp_valid <= tag_valid[MUL_LAT] ? (NREQ'(1) << tag_idx[MUL_LAT]) : '0;
      if (tag_valid[MUL_LAT]) rsp_prod <= mul_prod;
    end
  end

  // Busy covers operations still in the pipeline plus the response cycle itself.
  assign busy = (|tag_valid) | (|rsp_valid);

`ifdef MULARB_PERF_EN
  logic [31:0] perf_reg;

  // Count accepted operations; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       perf_reg <= '0;
    else if (grant) perf_reg <= perf_reg + 32'd1;
  end

  assign perf_cnt = perf_reg;
`else
  assign perf_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb_booth_mul_arbiter: scoreboard bench for booth_mul_arbiter. Acceptances are
// recorded on the falling edge and pushed into a queue with their expected
// product; a monitor just after each rising edge pops and compares responses.
module tb_booth_mul_arbiter;
  localparam int N       = 16;
  localparam int NREQ    = 4;
  localparam int MUL_LAT = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                en  = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*N-1:0]   req_a = '0;
  logic [NREQ*N-1:0]   req_b = '0;
  logic [NREQ-1:0]     req_ready;
  logic [N-1:0]        mul_a;
  logic [N-1:0]        mul_b;
  logic [2*N-1:0]      mul_prod;
  logic [NREQ-1:0]     rsp_valid;
  logic [2*N-1:0]      rsp_prod;
  logic                busy;
  logic [31:0]         perf_cnt;

  booth_mul_arbiter #(.N(N), .NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_a(req_a),
    .req_b(req_b), .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b),
    .mul_prod(mul_prod), .rsp_valid(rsp_valid), .rsp_prod(rsp_prod),
    .busy(busy), .perf_cnt(perf_cnt)
  );

  always #5 clk = ~clk;

  // Shared multiplier model: product appears MUL_LAT cycles after operands.
  logic signed [2*N-1:0] mpipe [MUL_LAT];
  initial for (int i = 0; i < MUL_LAT; i++) mpipe[i] = '0;
  always @(posedge clk) begin
    mpipe[0] <= $signed(mul_a) * $signed(mul_b);
    for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_prod = mpipe[MUL_LAT-1];

  typedef struct {
    int             idx;
    logic [2*N-1:0] prod;
    int             cyc;
  } exp_t;

  exp_t           sbq[$];
  exp_t           e;
  int             checks = 0;
  int             failures = 0;
  int             cyc = 0;
  int             last_gnt = NREQ - 1;
  int             resp_count = 0;
  logic [31:0]    model_cnt = '0;
  logic [2*N-1:0] last_prod = '0;
  logic [NREQ-1:0] exp_rdy;
  bit             found;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  function automatic logic [2*N-1:0] ref_prod(input int i);
    logic signed [N-1:0]   a;
    logic signed [N-1:0]   b;
    logic signed [2*N-1:0] p;
    a = req_a[i*N +: N];
    b = req_b[i*N +: N];
    p = a * b;
    return p;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Arbitration reference and acceptance capture, mid-cycle.
  always @(negedge clk) begin
    exp_rdy = '0;
    found   = 1'b0;
    if (rst && en) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (!found && req_valid[(last_gnt + k) % NREQ]) begin
          found = 1'b1;
          exp_rdy[(last_gnt + k) % NREQ] = 1'b1;
        end
      end
    end
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sbq.push_back('{idx: i, prod: ref_prod(i), cyc: cyc});
          last_gnt = i;
`ifdef MULARB_PERF_EN
          model_cnt = model_cnt + 32'd1;
`endif
          $display("ACCEPT cyc=%0d req=%0d a=%0h b=%0h", cyc, i, req_a[i*N +: N], req_b[i*N +: N]);
        end
      end
    end
  end

  // Response monitor, just after the rising edge.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_prod", 64'(rsp_prod), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_perf_cnt", 64'(perf_cnt), 64'd0);
      chk("rst_mul_a", 64'(mul_a), 64'd0);
      chk("rst_mul_b", 64'(mul_b), 64'd0);
    end else begin
      chk("busy", 64'(busy), 64'(sbq.size() != 0));
      if (rsp_valid != '0) begin
        if (sbq.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("rsp_valid", 64'(rsp_valid), 64'(1 << e.idx));
          chk("rsp_prod", 64'(rsp_prod), 64'(e.prod));
          chk("rsp_latency", 64'(cyc), 64'(e.cyc + MUL_LAT + 2));
          last_prod = e.prod;
          resp_count++;
          $display("RESP cyc=%0d req=%0d prod=%0h", cyc, e.idx, rsp_prod);
        end
      end else begin
        chk("rsp_prod_hold", 64'(rsp_prod), 64'(last_prod));
      end
      chk("perf_cnt", 64'(perf_cnt), 64'(model_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    sbq.delete();
    last_gnt  = NREQ - 1;
    model_cnt = '0;
    last_prod = '0;
    repeat (cycles) step();
    rst = 1'b1;
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (sbq.size() == 0) break;
      step();
    end
    chk("drain_timeout", 64'(sbq.size()), 64'd0);
    step();
    step();
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = N'($urandom);
      req_b[i*N +: N] = N'($urandom);
    end
  endtask

  logic [2*N-1:0] m15;
  int r0;

  initial begin
    m15 = -15;
    // Reset with everything requesting, then contention right after release.
    en = 1'b1;
    req_valid = '1;
    rand_ops();
    do_reset(3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("contention_grant", 64'(req_ready), 64'(1 << k));
      step();
    end
    req_valid = '0;
    drain(20);

    // Single operation 3 * -5 from requester 0.
    req_a[0 +: N] = N'(3);
    req_b[0 +: N] = N'(-5);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    repeat (4) step();
    chk("single_rsp_valid", 64'(rsp_valid), 64'b0001);
    chk("single_rsp_prod", 64'(rsp_prod), 64'(m15));
    step();
    chk("single_rsp_once", 64'(rsp_valid), 64'd0);
    drain(20);

    // Fairness: grant 1, then 0 and 2 compete -> 2 first, then 0.
    rand_ops();
    req_valid = 4'b0010;
    step();
    req_valid = 4'b0101;
    @(negedge clk);
    chk("fair_first", 64'(req_ready), 64'b0100);
    step();
    @(negedge clk);
    chk("fair_second", 64'(req_ready), 64'b0001);
    step();
    req_valid = '0;
    drain(20);

    // en drops with three operations in flight.
    r0 = resp_count;
    rand_ops();
    req_valid = '1;
    repeat (3) step();
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("en0_ready", 64'(req_ready), 64'd0);
      step();
    end
    drain(20);
    chk("en0_responses", 64'(resp_count - r0), 64'd3);
    req_valid = '0;
    en = 1'b1;

    // Reset with two operations in flight.
    rand_ops();
    req_valid = '1;
    repeat (2) step();
    req_valid = '0;
    step();
    do_reset(2);
    repeat (10) step();
    chk("post_reset_perf", 64'(perf_cnt), 64'd0);

    // Ten accepted operations for the counter build.
    req_valid = 4'b1001;
    for (int k = 0; k < 10; k++) begin
      rand_ops();
      step();
    end
    req_valid = '0;
`ifdef MULARB_PERF_EN
    chk("perf_ten", 64'(perf_cnt), 64'd10);
`else
    chk("perf_ten", 64'(perf_cnt), 64'd0);
`endif
    drain(20);

    // Randomized traffic with occasional enable drops and one mid-run reset.
    for (int k = 0; k < 400; k++) begin
      rand_ops();
      req_valid = NREQ'($urandom);
      en = ($urandom_range(0, 9) != 0);
      if (k == 200) do_reset(2);
      else step();
    end
    en = 1'b1;
    req_valid = '0;
    drain(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
